mips_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit for the MIPS datapath, parametrised successor to the single-cycle ALU.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/mips_muldiv_signfix.sv | 42 ++++
 rtl/mips_muldiv_unit.sv | 184 ++++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS multiply/divide unit.
// Build macro MIPS_MULDIV_DIV_EN enables the divider datapath.
package mips_pkg;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    OP_MULTU = 2'd0,
    OP_MULT  = 2'd1,
    OP_DIVU  = 2'd2,
    OP_DIV   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic op_is_div(
    input logic [1:0] op
  );
    return op[1];
  endfunction

  function automatic logic op_is_signed(
    input logic [1:0] op
  );
    return op[0];
  endfunction

endpackage

// File: rtl/mips_muldiv_signfix.sv
// Magnitude/sign conversion for operands entering and results leaving
// the multiply/divide unit (pure combinational).
module mips_muldiv_signfix
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               sgn,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  output logic [WIDTH-1:0]   rs_abs,
  output logic [WIDTH-1:0]   rt_abs,
  output logic               rs_neg,
  output logic               rt_neg,
  input  logic [2*WIDTH-1:0] acc,
  input  logic               is_div,
  input  logic               res_neg,
  input  logic               rem_neg,
  output logic [WIDTH-1:0]   fix_hi,
  output logic [WIDTH-1:0]   fix_lo
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  assign rs_neg = sgn & rs_val[WIDTH-1];
  assign rt_neg = sgn & rt_val[WIDTH-1];

  // |MIN| wraps back to MIN, which is the correct unsigned magnitude
  assign rs_abs = rs_neg ? -rs_val : rs_val;
  assign rt_abs = rt_neg ? -rt_val : rt_val;

  assign prod = res_neg ? -acc : acc;
  assign quot = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = rem_neg ? -acc[2*WIDTH-1:WIDTH]
                        : acc[2*WIDTH-1:WIDTH];

  assign fix_hi = is_div ? rem  : prod[2*WIDTH-1:WIDTH];
  assign fix_lo = is_div ? quot : prod[WIDTH-1:0];

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO, one bit per cycle.
// Divider present only when MIPS_MULDIV_DIV_EN is defined.
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_FIX  = FIX;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] step;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               dbz_q;
  logic               res_neg;

  logic [WIDTH-1:0]   rs_abs;
  logic [WIDTH-1:0]   rt_abs;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic [WIDTH:0]     mul_sum;

`ifdef MIPS_MULDIV_DIV_EN
  logic               is_div;
  logic               rem_neg;
  logic               dbz_op;
  logic [2*WIDTH:0]   div_sh;
  logic [WIDTH:0]     div_rem;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
`endif

  mips_muldiv_signfix #(
    .WIDTH(WIDTH)
  ) u_signfix (
    .sgn     (op_is_signed(op)),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .rs_abs  (rs_abs),
    .rt_abs  (rt_abs),
    .rs_neg  (rs_neg),
    .rt_neg  (rt_neg),
    .acc     (acc),
`ifdef MIPS_MULDIV_DIV_EN
    .is_div  (is_div),
    .rem_neg (rem_neg),
`else
    .is_div  (1'b0),
    .rem_neg (1'b0),
`endif
    .res_neg (res_neg),
    .fix_hi  (fix_hi),
    .fix_lo  (fix_lo)
  );

  // Shift-add keeps the multiplier in acc low half, product grows from top
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
            + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    step    = {mul_sum, acc[WIDTH-1:1]};
`ifdef MIPS_MULDIV_DIV_EN
    div_sh   = {acc, 1'b0};
    div_rem  = div_sh[2*WIDTH:WIDTH];
    div_diff = div_rem - {1'b0, opnd};
    div_ok   = ~div_diff[WIDTH];
    if (is_div) begin
      step = {(div_ok ? div_diff[WIDTH-1:0]
                      : div_rem[WIDTH-1:0]),
              div_sh[WIDTH-1:1], div_ok};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
      res_neg <= 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
      is_div  <= 1'b0;
      rem_neg <= 1'b0;
      dbz_op  <= 1'b0;
`endif
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
`ifdef MIPS_MULDIV_DIV_EN
            state   <= S_CALC;
            cnt     <= CNT_W'(WIDTH);
            is_div  <= op_is_div(op);
            res_neg <= rs_neg ^ rt_neg;
            rem_neg <= rs_neg;
            dbz_op  <= op_is_div(op) && (rt_val == '0);
            if (op_is_div(op)) begin
              opnd <= rt_abs;
              acc  <= {{WIDTH{1'b0}}, rs_abs};
            end else begin
              opnd <= rs_abs;
              acc  <= {{WIDTH{1'b0}}, rt_abs};
            end
`else
            // No divider: divides finish at once as illegal ops
            if (op_is_div(op)) begin
              state <= S_DONE;
              dbz_q <= 1'b1;
            end else begin
              state   <= S_CALC;
              cnt     <= CNT_W'(WIDTH);
              res_neg <= rs_neg ^ rt_neg;
              opnd    <= rs_abs;
              acc     <= {{WIDTH{1'b0}}, rt_abs};
            end
`endif
          end
        end
        S_CALC: begin
          if (cnt == '0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - 1'b1;
            acc <= step;
          end
        end
        S_FIX: begin
          state <= S_DONE;
          hi_q  <= fix_hi;
`ifdef MIPS_MULDIV_DIV_EN
          lo_q  <= dbz_op ? {WIDTH{1'b1}} : fix_lo;
          dbz_q <= dbz_op;
`else
          lo_q  <= fix_lo;
          dbz_q <= 1'b0;
`endif
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready    = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign out_valid   = (state == S_DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: cycle model plus literals.
// Divide vectors adapt to MIPS_MULDIV_DIV_EN.
module tb_mips_muldiv_unit;

  localparam int W = 32;
`ifdef MIPS_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [W-1:0]  rs_val;
  logic [W-1:0]  rt_val;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          busy;
  logic          div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h want %h",
               name, cyc, act, exp);
    end
  endtask

  // Architectural result of one op, straight from the ISA rules
  task automatic model_result(input  logic [1:0] o,
                              input  logic [W-1:0] a,
                              input  logic [W-1:0] b,
                              output logic [W-1:0] h,
                              output logic [W-1:0] l,
                              output logic z);
    longint sa, sb, sp, q, r;
    longint unsigned up;
    sa = $signed(a);
    sb = $signed(b);
    z  = 1'b0;
    case (o)
      2'd0: begin
        up = {32'b0, a} * {32'b0, b};
        h = up[63:32];
        l = up[31:0];
      end
      2'd1: begin
        sp = sa * sb;
        h = sp[63:32];
        l = sp[31:0];
      end
      default: begin
        if (b == 0) begin
          h = a;
          l = '1;
          z = 1'b1;
        end else if (o == 2'd2) begin
          l = a / b;
          h = a % b;
        end else begin
          q = sa / sb;
          r = sa % sb;
          l = q[31:0];
          h = r[31:0];
        end
      end
    endcase
  endtask

  bit            m_busy, m_done, m_dbz, p_dbz;
  int            m_rem;
  logic [W-1:0]  m_hi, m_lo, p_hi, p_lo;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_rem = 0;
      m_hi = '0; m_lo = '0; m_dbz = 0;
    end else if (!m_busy && !m_done) begin
      if (in_valid && !flush) begin
        model_result(op, rs_val, rt_val,
                     p_hi, p_lo, p_dbz);
        if (op[1] && !DIV_EN) begin
          m_done = 1;
          m_dbz  = 1;
        end else begin
          m_busy = 1;
          m_rem  = W + 2;
        end
      end
    end else if (flush) begin
      m_busy = 0;
      m_done = 0;
    end else if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 0; m_done = 1;
        m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz;
      end
    end else if (out_ready) begin
      m_done = 0;
    end
  end

  always @(negedge clk) begin
    chk("ctrl", {in_ready, busy, out_valid, div_by_zero},
        {!(m_busy || m_done), (m_busy || m_done),
         m_done, m_dbz});
    chk("hilo", {hi, lo}, {m_hi, m_lo});
  end

  task automatic issue(input logic [1:0] o,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       output int acc_cyc);
    int k;
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    op = o; rs_val = a; rt_val = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input int hold,
                        input bit poke,
                        output int lat);
    int acc_cyc, k;
    issue(o, a, b, acc_cyc);
    k = 0;
    lat = -1;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (out_valid) break;
      if (poke) begin
        in_valid = (k <= 3);
        op = 2'd0; rs_val = 32'd9; rt_val = 32'd9;
      end
    end
    in_valid = 1'b0;
    if (!out_valid) chk("done_timeout", 0, 1);
    else lat = cyc - acc_cyc;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acc_cyc, k;
    bit seen;
    logic [W-1:0] keep_hi, keep_lo;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    out_ready = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_ctrl", {in_ready, busy, out_valid, div_by_zero},
        4'b1000);

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1, lat);
    chk("multu_lat", lat, 34);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    run_op(2'd1, 32'hFFFF_FFFD, 32'd7, 0, 0, lat);
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo, 32'hFFFF_FFEB);

    run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 1, 0, lat);
    chk("mult_min_hi", hi, 32'h4000_0000);
    chk("mult_min_lo", lo, 32'h0);

`ifdef MIPS_MULDIV_DIV_EN
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, lat);
    chk("div_lat", lat, 34);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);
    chk("div_neg_dbz", div_by_zero, 0);
    run_op(2'd2, 32'd100, 32'd7, 0, 0, lat);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, lat);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0);
    run_op(2'd2, 32'd5, 32'd0, 0, 0, lat);
    chk("dbz_lat", lat, 34);
    chk("dbz_lo", lo, 32'hFFFF_FFFF);
    chk("dbz_hi", hi, 32'd5);
    chk("dbz_flag", div_by_zero, 1);
    run_op(2'd3, 32'hFFFF_FFF0, 32'd0, 0, 0, lat);
    chk("sdbz_hi", hi, 32'hFFFF_FFF0);
    chk("sdbz_lo", lo, 32'hFFFF_FFFF);
`else
    run_op(2'd2, 32'd5, 32'd0, 2, 0, lat);
    chk("nodiv_lat", lat, 0);
    chk("nodiv_hi", hi, 32'h4000_0000);
    chk("nodiv_lo", lo, 32'h0);
    chk("nodiv_flag", div_by_zero, 1);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, lat);
    chk("nodiv_s_hi", hi, 32'h4000_0000);
`endif

    run_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, lat);
    run_op(2'd1, 32'd7, 32'hFFFF_FFFF, 0, 0, lat);
    chk("mult_m1_hi", hi, 32'hFFFF_FFFF);
    chk("mult_m1_lo", lo, 32'hFFFF_FFF9);
    chk("mult_m1_dbz", div_by_zero, 0);

    // abort a multiply mid-calculation
    keep_hi = m_hi;
    keep_lo = m_lo;
    issue(2'd0, 32'd1000, 32'd1000, acc_cyc);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_hilo", {hi, lo}, {keep_hi, keep_lo});
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("flush_no_valid", seen, 0);

    // flush beats a same-cycle request in IDLE
    @(posedge clk);
    #1 flush = 1'b1; in_valid = 1'b1;
    op = 2'd0; rs_val = 32'd3; rt_val = 32'd3;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_idle_busy", busy, 0);

    issue(2'd1, 32'd3, 32'd3, acc_cyc);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_ctrl", {in_ready, busy, out_valid, div_by_zero},
        4'b1000);
    #3 rst_n = 1'b1;

    run_op(2'd0, 32'd6, 32'd7, 0, 0, lat);
    chk("post_rst_lo", lo, 32'd42);
    k = 0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
